rom_stream_reader: RTL and testbench
====================================

Name: rom_stream_reader

Overview:
- Sequences burst reads from a `rom_sync` instance with fixed 1-cycle read latency: start address plus length in, one word per cycle out on a valid/ready stream.
- Sits directly upstream of `rom_sync` (drives its `addr`, consumes its `data`) and feeds downstream consumers such as sprite/line renderers.
- Absorbs ROM latency and downstream backpressure with an internal 4-entry FIFO and a credit scheme, so the ROM is never read without space reserved for the result.

Parameters:
- WIDTH, 8, ROM word width; must match the attached `rom_sync`.
- DEPTH, 256, ROM depth in words; any value ≥2, need not be a power of two.
- ADDRW, $clog2(DEPTH), localparam: address width.
- LENW, ADDRW+1, localparam: burst length width, allowing len = DEPTH.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- start  input  1  burst request; sampled on clk rising edge
- start_addr  input  ADDRW  first ROM address of the burst
- len  input  LENW  words in the burst; 0..DEPTH
- busy  output  1  burst in progress
- done  output  1  single-cycle pulse at burst completion
- rom_addr  output  ADDRW  registered address to `rom_sync.addr`
- rom_data  input  WIDTH  from `rom_sync.data`; valid the cycle after rom_addr is presented
- m_data  output  WIDTH  stream data
- m_valid  output  1  stream valid
- m_ready  input  1  stream ready from consumer
- m_last  output  1  marks the final word of the burst

Behaviour:
- Reset (async assert, sync release):
  - busy=0, done=0, rom_addr=0, m_valid=0, m_last=0, m_data=0.
  - FIFO emptied, in-flight count=0, state IDLE.
  - Reset mid-burst abandons the burst with no done pulse; ROM data returned after reset is discarded.
- States:
  - IDLE: start=1 and len>0 → ISSUE; latch remaining=len; rom_addr<=start_addr; busy<=1.
  - IDLE: start=1 and len=0 → done=1 for one cycle; stay IDLE; busy stays 0.
  - ISSUE: while reads issued < len, issue one read per cycle when credit allows (see below). After the final read issues → DRAIN.
  - DRAIN: wait until the final word (m_last) completes its handshake → IDLE. On that same edge: busy<=0, done<=1 for one cycle.
- start is ignored while busy=1; no queuing.
- Issue pipeline:
  - An issued read presents its address on rom_addr.
  - rom_data is captured into the FIFO two edges after the issue edge (ROM register stage, then capture).
  - In-flight count covers issued reads not yet written to the FIFO; range 0..2.
- Credit rule: issue only when FIFO occupancy + in-flight < 4, using registered values (same-cycle pop not counted). FIFO overflow is impossible by construction.
- Throughput: with m_ready held high, one word per cycle after the initial latency.
- Latency: start sampled at edge E0 → m_valid first high after edge E2.
- Address arithmetic:
  - rom_addr advances by 1 per issued read.
  - At DEPTH-1 it wraps to 0, with an explicit compare, not power-of-two overflow.
  - A burst may cross the wrap point.
- Stream rules:
  - m_data, m_valid and m_last come from the FIFO head and are stable while m_valid=1 and m_ready=0.
  - Handshake occurs when m_valid & m_ready on a clk edge.
  - m_last=1 only with the len-th word.
  - A FIFO push and pop in the same cycle are both honoured.
- len=DEPTH reads every location exactly once, starting at start_addr.
- busy stays high from the start edge until the done edge inclusive of DRAIN; done and busy are never high together.

Test Plan:
- ROM holds data=address (DEPTH=256). start_addr=0x10, len=4, m_ready=1 → m_data 0x10,0x11,0x12,0x13 on consecutive cycles; first m_valid 2 cycles after start; m_last on 0x13; done pulses the cycle after the 0x13 handshake; busy low on that edge.
- Same burst with m_ready toggling 1,0,0,1,0,1… → no lost or duplicated words; m_data held while stalled; FIFO occupancy + in-flight never exceeds 4; rom_addr stops advancing while credits are exhausted.
- start_addr=0xFE, len=4 → rom_addr sequence 0xFE,0xFF,0x00,0x01; output matches. With DEPTH=200 and start_addr=198, len=3 → 198,199,0.
- len=0 → done pulse one cycle after start; no m_valid; busy stays 0. len=256 from 0x80 → 256 words, m_last on 0x7F.
- start re-asserted mid-burst with different start_addr/len → ignored; original burst completes unchanged.
- rst asserted asynchronously mid-burst between edges → outputs zero immediately; after release, a new burst (start_addr=0x40, len=2) produces exactly 0x40,0x41 with no stale data.

Source files
------------

// File: rtl/rom_stream_reader.sv
// Burst reader for a 1-cycle-latency synchronous ROM: start address + length in,
// valid/ready word stream out, with a 4-entry FIFO and credit-gated read issue.
module rom_stream_reader #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(DEPTH)-1:0]   start_addr,
  input  logic [$clog2(DEPTH):0]     len,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH)-1:0]   rom_addr,
  input  logic [WIDTH-1:0]           rom_data,
  output logic [WIDTH-1:0]           m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       m_last
);

  localparam int unsigned ADDRW  = $clog2(DEPTH);
  localparam int unsigned LENW   = ADDRW + 1;
  localparam int unsigned FIFO_D = 4;
  localparam int unsigned CNTW   = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                        state_q, state_d;
  logic                          busy_d, done_d;
  logic [ADDRW-1:0]              addr_d, addr_inc;
  logic [LENW-1:0]               remaining_q, remaining_d;
  logic                          issue, issue_last, credit_ok;

  // Read pipeline: stage 1 = address presented, stage 2 = ROM output valid.
  logic                          v1_q, v2_q, l1_q, l2_q;

  // Shift-register FIFO; entry 0 is the stream head and drives the outputs directly.
  logic [FIFO_D-1:0][WIDTH-1:0]  mem_q, mem_d;
  logic [FIFO_D-1:0]             lst_q, lst_d;
  logic [FIFO_D-1:0]             vld_q, vld_d;
  logic [CNTW-1:0]               cnt_q, cnt_d;
  logic [CNTW-1:0]               wr_idx;
  logic                          push, pop;

  assign m_data  = mem_q[0];
  assign m_last  = lst_q[0];
  assign m_valid = vld_q[0];

  assign pop       = vld_q[0] & m_ready;
  assign push      = v2_q;
  assign credit_ok = (4'(cnt_q) + 4'(v1_q) + 4'(v2_q)) < 4'(FIFO_D);
  assign addr_inc  = (rom_addr == ADDRW'(DEPTH - 1)) ? '0 : rom_addr + ADDRW'(1);
  assign wr_idx    = pop ? cnt_q - CNTW'(1) : cnt_q;

  // Next-state and issue decisions.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy;
    done_d      = 1'b0;
    addr_d      = rom_addr;
    remaining_d = remaining_q;
    issue       = 1'b0;
    issue_last  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            issue       = 1'b1;
            issue_last  = (len == LENW'(1));
            addr_d      = start_addr;
            remaining_d = len - LENW'(1);
            busy_d      = 1'b1;
            state_d     = (len == LENW'(1)) ? DRAIN : ISSUE;
          end
        end
      end
      ISSUE: begin
        if (credit_ok) begin
          issue       = 1'b1;
          issue_last  = (remaining_q == LENW'(1));
          addr_d      = addr_inc;
          remaining_d = remaining_q - LENW'(1);
          if (remaining_q == LENW'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && lst_q[0]) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO update; simultaneous push and pop keep the count unchanged.
  always_comb begin
    mem_d = mem_q;
    lst_d = lst_q;
    cnt_d = cnt_q;
    if (pop) begin
      for (int i = 0; i < FIFO_D - 1; i++) begin
        mem_d[i] = mem_q[i+1];
        lst_d[i] = lst_q[i+1];
      end
      mem_d[FIFO_D-1] = '0;
      lst_d[FIFO_D-1] = 1'b0;
      cnt_d = cnt_q - CNTW'(1);
    end
    if (push) begin
      mem_d[wr_idx[1:0]] = rom_data;
      lst_d[wr_idx[1:0]] = l2_q;
      cnt_d = pop ? cnt_q : cnt_q + CNTW'(1);
    end
    for (int i = 0; i < FIFO_D; i++) begin
      vld_d[i] = CNTW'(i) < cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      rom_addr    <= '0;
      remaining_q <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      l1_q        <= 1'b0;
      l2_q        <= 1'b0;
      mem_q       <= '0;
      lst_q       <= '0;
      vld_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      busy        <= busy_d;
      done        <= done_d;
      rom_addr    <= addr_d;
      remaining_q <= remaining_d;
      v1_q        <= issue;
      l1_q        <= issue_last;
      v2_q        <= v1_q;
      l2_q        <= l1_q;
      mem_q       <= mem_d;
      lst_q       <= lst_d;
      vld_q       <= vld_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader against a data=address ROM model,
// with a second DEPTH=200 instance for the non-power-of-two wrap.
module tb_rom_stream_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] start_addr;
  logic [8:0] len;
  logic       busy, done;
  logic [7:0] rom_addr, rom_q;
  logic [7:0] m_data;
  logic       m_valid, m_ready, m_last;

  logic       b_start;
  logic [7:0] b_start_addr;
  logic [8:0] b_len;
  logic       b_busy, b_done;
  logic [7:0] b_rom_addr, b_rom_q;
  logic [7:0] b_m_data;
  logic       b_m_valid, b_m_ready, b_m_last;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] q_data[$];
  bit         q_last[$];

  always #5 clk = ~clk;

  rom_stream_reader #(.WIDTH(8), .DEPTH(256)) u_dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .len(len),
    .busy(busy), .done(done), .rom_addr(rom_addr), .rom_data(rom_q),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  rom_stream_reader #(.WIDTH(8), .DEPTH(200)) u_d200 (
    .clk(clk), .rst(rst), .start(b_start), .start_addr(b_start_addr), .len(b_len),
    .busy(b_busy), .done(b_done), .rom_addr(b_rom_addr), .rom_data(b_rom_q),
    .m_data(b_m_data), .m_valid(b_m_valid), .m_ready(b_m_ready), .m_last(b_m_last)
  );

  // ROM models: data = address, one-cycle registered read.
  always @(posedge clk) begin
    rom_q   <= rom_addr;
    b_rom_q <= b_rom_addr;
  end

  // Handshake monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      q_data.push_back(m_data);
      q_last.push_back(m_last);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic [7:0] a, input logic [8:0] l);
    start      = 1'b1;
    start_addr = a;
    len        = l;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit toggle);
    logic [5:0] pat = 6'b101001;
    bit         got = 1'b0;
    bit         stall;
    logic [7:0] held;
    for (int c = 0; c < budget && !got; c++) begin
      m_ready = toggle ? pat[c % 6] : 1'b1;
      stall   = m_valid && !m_ready;
      held    = m_data;
      tick();
      if (stall) check("hold", 32'(m_data), 32'(held));
      if (done) got = 1'b1;
    end
    check("done_seen", 32'(got), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    m_ready = 1'b1;
  endtask

  task automatic check_queue(input int base, input int n);
    check("count", 32'(q_data.size()), 32'(n));
    for (int i = 0; i < n && i < q_data.size(); i++) begin
      check("word", 32'(q_data[i]), 32'((base + i) % 256));
      check("last", 32'(q_last[i]), 32'(i == n - 1));
    end
    q_data.delete();
    q_last.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_addr = '0; len = '0; m_ready = 1'b1;
    b_start = 1'b0; b_start_addr = '0; b_len = '0; b_m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_addr", 32'(rom_addr), 0);
    check("rst_valid", 32'(m_valid), 0);
    check("rst_last", 32'(m_last), 0);
    check("rst_data", 32'(m_data), 0);
    rst = 1'b0;
    tick();

    // Basic burst, exact cycle timing.
    start_burst(8'h10, 9'd4);
    check("e0_busy", 32'(busy), 1);
    check("e0_addr", 32'(rom_addr), 32'h10);
    check("e0_valid", 32'(m_valid), 0);
    tick();
    check("e1_valid", 32'(m_valid), 0);
    tick();
    check("e2_valid", 32'(m_valid), 1);
    check("e2_data", 32'(m_data), 32'h10);
    tick();
    check("e3_data", 32'(m_data), 32'h11);
    tick();
    check("e4_data", 32'(m_data), 32'h12);
    check("e4_last", 32'(m_last), 0);
    tick();
    check("e5_data", 32'(m_data), 32'h13);
    check("e5_last", 32'(m_last), 1);
    check("e5_done", 32'(done), 0);
    tick();
    check("e6_done", 32'(done), 1);
    check("e6_busy", 32'(busy), 0);
    check("e6_valid", 32'(m_valid), 0);
    tick();
    check("e7_done", 32'(done), 0);
    check_queue(32'h10, 4);

    // Toggling backpressure.
    start_burst(8'h10, 9'd4);
    wait_done(50, 1'b1);
    check_queue(32'h10, 4);

    // Full stall: credits run out after four reads.
    m_ready = 1'b0;
    start_burst(8'h10, 9'd8);
    repeat (8) tick();
    check("stall_addr", 32'(rom_addr), 32'h13);
    check("stall_valid", 32'(m_valid), 1);
    check("stall_data", 32'(m_data), 32'h10);
    wait_done(60, 1'b0);
    check_queue(32'h10, 8);

    // Wrap at 255.
    start_burst(8'hFE, 9'd4);
    check("wrap_a0", 32'(rom_addr), 32'hFE);
    tick();
    check("wrap_a1", 32'(rom_addr), 32'hFF);
    tick();
    check("wrap_a2", 32'(rom_addr), 32'h00);
    wait_done(40, 1'b0);
    check_queue(32'hFE, 4);

    // DEPTH=200 wrap at 199.
    b_start = 1'b1; b_start_addr = 8'd198; b_len = 9'd3;
    tick();
    b_start = 1'b0;
    check("d200_a0", 32'(b_rom_addr), 198);
    tick();
    check("d200_a1", 32'(b_rom_addr), 199);
    tick();
    check("d200_a2", 32'(b_rom_addr), 0);
    check("d200_w0", 32'(b_m_data), 198);
    tick();
    check("d200_w1", 32'(b_m_data), 199);
    tick();
    check("d200_w2", 32'(b_m_data), 0);
    check("d200_last", 32'(b_m_last), 1);
    tick();
    check("d200_done", 32'(b_done), 1);
    check("d200_busy", 32'(b_busy), 0);

    // Zero-length burst.
    start_burst(8'h55, 9'd0);
    check("len0_done", 32'(done), 1);
    check("len0_busy", 32'(busy), 0);
    check("len0_valid", 32'(m_valid), 0);
    tick();
    check("len0_done2", 32'(done), 0);
    check("len0_valid2", 32'(m_valid), 0);
    check_queue(0, 0);

    // Full-depth burst.
    start_burst(8'h80, 9'd256);
    wait_done(400, 1'b0);
    check_queue(32'h80, 256);

    // start while busy is ignored.
    start_burst(8'h20, 9'd5);
    tick();
    start_burst(8'h90, 9'd2);
    wait_done(40, 1'b0);
    check_queue(32'h20, 5);
    repeat (4) tick();
    check("ignored_idle_busy", 32'(busy), 0);
    check_queue(0, 0);

    // Asynchronous reset mid-burst.
    start_burst(8'h30, 9'd8);
    repeat (3) tick();
    #3 rst = 1'b1;
    #1;
    check("arst_valid", 32'(m_valid), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_addr", 32'(rom_addr), 0);
    check("arst_data", 32'(m_data), 0);
    check("arst_last", 32'(m_last), 0);
    #2 rst = 1'b0;
    tick();
    tick();
    check("arst_done", 32'(done), 0);
    q_data.delete();
    q_last.delete();
    start_burst(8'h40, 9'd2);
    wait_done(30, 1'b0);
    repeat (4) tick();
    check_queue(32'h40, 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
